tdc_event_packer: RTL

- Upstream neighbour of the SiTCP TCP transmit path, running on the 200 MHz system clock.
- Accepts TDC hits (channel plus 32-bit timestamp) and event-end markers through a valid/ready handshake, and buffers them in a small hit FIFO.
- Serialises each event into a byte frame (header, hits, trailer) on the TCP TX byte interface, throttled by the TX FIFO programmable-full flag.
- Flushes itself whenever the TCP connection is not open.

---
 rtl/tdc_packer_pkg.sv | 36 +++
 rtl/tdc_hit_fifo.sv | 77 +++++++
 rtl/tdc_event_packer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tdc_packer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tdc_packer_pkg                                                         |
// | Shared types and frame constants for the TDC event packer.             |
// | Optional: TDC_PACKER_CHECKSUM_EN adds an XOR checksum trailer byte.    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package tdc_packer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        POP  = 3'd2,
        HIT  = 3'd3,
        TRL  = 3'd4
    } state_t;

    typedef struct packed {
        logic        has_hit;
        logic        evt_end;
        logic [7:0]  ch;
        logic [31:0] tstamp;
    } entry_t;

    localparam int         ENTRY_W  = $bits(entry_t);
    localparam logic [2:0] HDR_LEN  = 3'd3;
    localparam logic [2:0] HIT_LEN  = 3'd5;
`ifdef TDC_PACKER_CHECKSUM_EN
    localparam logic [2:0] TRL_LEN  = 3'd4;
`else
    localparam logic [2:0] TRL_LEN  = 3'd3;
`endif
    localparam logic [7:0] MAX_HITS = 8'd255;

endpackage
`default_nettype wire

// File: rtl/tdc_hit_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tdc_hit_fifo                                                           |
// | Synchronous show-ahead FIFO with synchronous flush (srst).             |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tdc_hit_fifo #(
    parameter int WIDTH      = 42,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_full_next,
    output logic             o_empty
);

    localparam logic [DEPTH_LOG2:0] c_full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_one      = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_wr;
    logic                  w_rd;

    assign w_wr        = i_wr & ~o_full;
    assign w_rd        = i_rd & ~o_empty;
    assign o_full      = (r_count == c_full_cnt);
    assign o_empty     = (r_count == '0);
    assign o_full_next = (w_count_next == c_full_cnt);
    assign o_rdata     = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (srst) begin
            w_count_next = '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   w_count_next = r_count + c_one;
                2'b01:   w_count_next = r_count - c_one;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (srst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/tdc_event_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tdc_event_packer                                                       |
// | Buffers TDC hits and serialises each event into a TCP TX byte frame.   |
// | Optional: TDC_PACKER_CHECKSUM_EN appends an XOR checksum byte.         |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tdc_event_packer
    import tdc_packer_pkg::*;
#(
    parameter int         HIT_DEPTH_LOG2 = 6,
    parameter logic [7:0] HEADER_BYTE    = 8'hAA,
    parameter logic [7:0] TRAILER_BYTE   = 8'h55
) (
    input  logic        CLK,
    input  logic        SYS_RSTn,
    input  logic        TCP_OPEN_ACK_IN,
    input  logic        HIT_VALID,
    output logic        HIT_READY,
    input  logic [7:0]  HIT_CH,
    input  logic [31:0] HIT_TIME,
    input  logic        HIT_EVT_END,
    input  logic        HIT_IS_MARKER,
    input  logic        FIFO_FULL_IN,
    output logic [7:0]  TCP_TX_DATA_OUT,
    output logic        TCP_TX_EN_OUT,
    output logic [15:0] DROP_CNT
);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_idx;
    logic [7:0]  r_hits;
    logic        r_ovf;
    logic [15:0] r_evt_cnt;
    logic [15:0] r_drop_cnt;
    logic        r_hit_ready;
    logic        r_tx_en;
    logic [7:0]  r_tx_data;
`ifdef TDC_PACKER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_flush;
    logic        w_wr;
    logic        w_pop;
    logic        w_emit;
    logic        w_last_byte;
    logic        w_drop;
    logic        w_full;
    logic        w_full_next;
    logic        w_empty;
    logic [7:0]  w_byte;
    entry_t      w_head;
    entry_t      w_wentry;

    assign w_flush  = ~TCP_OPEN_ACK_IN;
    assign w_wr     = HIT_VALID & r_hit_ready;
    assign w_wentry = {~HIT_IS_MARKER, HIT_EVT_END, HIT_CH, HIT_TIME};

    tdc_hit_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (HIT_DEPTH_LOG2)
    ) u_hit_fifo (
        .clk         (CLK),
        .rst_n       (SYS_RSTn),
        .srst        (w_flush),
        .i_wr        (w_wr),
        .i_wdata     (w_wentry),
        .i_rd        (w_pop),
        .o_rdata     (w_head),
        .o_full      (w_full),
        .o_full_next (w_full_next),
        .o_empty     (w_empty)
    );

    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) r_state <= IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_emit       = 1'b0;
        w_byte       = 8'h00;
        w_last_byte  = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_state_next = HDR;
            end
            HDR: begin
                w_emit      = ~FIFO_FULL_IN;
                w_last_byte = (r_idx == HDR_LEN - 3'd1);
                case (r_idx)
                    3'd0:    w_byte = HEADER_BYTE;
                    3'd1:    w_byte = r_evt_cnt[15:8];
                    default: w_byte = r_evt_cnt[7:0];
                endcase
                if (w_emit && w_last_byte) w_state_next = POP;
            end
            POP: begin
                if (!w_empty) begin
                    if (w_head.has_hit && (r_hits != MAX_HITS)) begin
                        w_state_next = HIT;
                    end else begin
                        // Saturated hits, end markers and no-ops are consumed here.
                        w_pop  = 1'b1;
                        w_drop = w_head.has_hit;
                        if (w_head.evt_end) w_state_next = TRL;
                    end
                end
            end
            HIT: begin
                w_emit      = ~FIFO_FULL_IN;
                w_last_byte = (r_idx == HIT_LEN - 3'd1);
                case (r_idx)
                    3'd0:    w_byte = w_head.ch;
                    3'd1:    w_byte = w_head.tstamp[31:24];
                    3'd2:    w_byte = w_head.tstamp[23:16];
                    3'd3:    w_byte = w_head.tstamp[15:8];
                    default: w_byte = w_head.tstamp[7:0];
                endcase
                if (w_emit && w_last_byte) begin
                    w_pop        = 1'b1;
                    w_state_next = w_head.evt_end ? TRL : POP;
                end
            end
            TRL: begin
                w_emit      = ~FIFO_FULL_IN;
                w_last_byte = (r_idx == TRL_LEN - 3'd1);
                case (r_idx)
                    3'd0:    w_byte = TRAILER_BYTE;
                    3'd1:    w_byte = r_hits;
`ifdef TDC_PACKER_CHECKSUM_EN
                    3'd2:    w_byte = {7'b0, r_ovf};
                    default: w_byte = r_csum;
`else
                    default: w_byte = {7'b0, r_ovf};
`endif
                endcase
                if (w_emit && w_last_byte) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_flush) begin
            w_state_next = IDLE;
            w_pop        = 1'b0;
            w_emit       = 1'b0;
            w_drop       = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            r_idx       <= 3'd0;
            r_hits      <= 8'd0;
            r_ovf       <= 1'b0;
            r_evt_cnt   <= 16'd0;
            r_hit_ready <= 1'b0;
            r_tx_en     <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            // Registered ready drops in the same edge that fills the FIFO.
            r_hit_ready <= TCP_OPEN_ACK_IN & ~w_full_next;
            r_tx_en     <= w_emit;
            if (w_flush) begin
                r_idx     <= 3'd0;
                r_hits    <= 8'd0;
                r_ovf     <= 1'b0;
                r_evt_cnt <= 16'd0;
            end else begin
                if (w_emit) begin
                    r_tx_data <= w_byte;
                    r_idx     <= w_last_byte ? 3'd0 : r_idx + 3'd1;
                end
                if (w_drop) r_ovf <= 1'b1;
                if ((r_state == HIT) && w_emit && w_last_byte && (r_hits != MAX_HITS))
                    r_hits <= r_hits + 8'd1;
                if ((r_state == TRL) && w_emit && w_last_byte) begin
                    r_evt_cnt <= r_evt_cnt + 16'd1;
                    r_hits    <= 8'd0;
                    r_ovf     <= 1'b0;
                end
            end
        end
    end

    // Drop count survives a connection flush.
    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn)                             r_drop_cnt <= 16'd0;
        else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

`ifdef TDC_PACKER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge SYS_RSTn) begin
        if (!SYS_RSTn)   r_csum <= 8'h00;
        else if (w_flush) r_csum <= 8'h00;
        else if (w_emit)  r_csum <= ((r_state == TRL) && w_last_byte) ? 8'h00 : (r_csum ^ w_byte);
    end
`endif

    assign HIT_READY       = r_hit_ready;
    assign TCP_TX_EN_OUT   = r_tx_en;
    assign TCP_TX_DATA_OUT = r_tx_data;
    assign DROP_CNT        = r_drop_cnt;

endmodule
`default_nettype wire
